top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Port order SHALL be A, B, C, F, clk, rst, m, ones, f_q, f_rise, hits; a four-port positional hookup (A, B, C, F) SHALL yield a working combinational F.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  1  operand bit, MSB of index {A,B,C}.
REQ-005 B  input  1  operand bit, middle of index.
REQ-006 C  input  1  operand bit, LSB of index.
REQ-007 F  output  1  combinational majority of A, B, C.
REQ-008 m  output  8  combinational one-hot minterm; m[{A,B,C}] = 1.
REQ-009 ones  output  2  combinational population count of A, B, C (0-3).
REQ-010 f_q  output  1  F registered one cycle.
REQ-011 f_rise  output  1  registered pulse marking an F 0->1 transition.
REQ-012 hits  output  16  count of clock edges sampling F = 1, saturating.

Function
REQ-013 F SHALL equal (A&B)|(A&C)|(B&C), purely combinational, zero latency, independent of clk and rst.
- Truth table by {A,B,C} = 000..111 is F = 0,0,0,1,0,1,1,1.
REQ-014 m SHALL have exactly one bit set, at index {A,B,C} (A weight 4, B weight 2, C weight 1); combinational.
REQ-015 ones SHALL equal A+B+C as an unsigned 2-bit value; combinational.
REQ-016 F SHALL be 1 exactly when ones >= 2.
REQ-017 Each rising clk edge with rst = 0: f_q SHALL take the value of F sampled at that edge.
REQ-018 Each rising clk edge with rst = 0: f_rise SHALL be 1 iff F = 1 and the previous f_q = 0; otherwise 0.
- f_rise is one cycle wide.
REQ-019 Each rising clk edge with rst = 0 and F = 1: hits SHALL increment by 1.
- At 16'hFFFF, hits SHALL hold (saturate, no wrap).
REQ-020 Each rising clk edge with rst = 0 and F = 0: hits SHALL hold.
REQ-021 Combinational outputs (F, m, ones) SHALL never be X when A, B, C are known, including while clk is undriven.

Reset
REQ-022 rst = 1 at a rising clk edge SHALL set f_q = 0, f_rise = 0, hits = 0.
- rst has priority over every other update in that cycle.
REQ-023 rst SHALL NOT affect F, m or ones.
REQ-024 Asserting rst mid-count SHALL clear hits at the next edge.
REQ-025 On the first edge after rst deasserts, F = 1 SHALL produce f_rise = 1 and hits = 1.

Verification
REQ-026 {A,B,C} = 110, no clock, wait 5 ns -> F = 1, m = 8'b0100_0000, ones = 2.
REQ-027 Sweep {A,B,C} = 000..111 -> F = 0,0,0,1,0,1,1,1; ones = 0,1,1,2,1,2,2,3; m = 1<<index.
REQ-028 rst = 1 for 2 edges, then {A,B,C} = 111 for 3 edges -> f_rise = 1 on first edge only; f_q = 1; hits = 3.
REQ-029 From hits = 5, set {A,B,C} = 100 for 4 edges -> hits stays 5, f_q = 0, f_rise = 0.
REQ-030 Preload by driving F = 1 for 65,535 edges (hits = 16'hFFFF), then 2 more edges -> hits stays 16'hFFFF.
REQ-031 hits = 7, assert rst for one edge with {A,B,C} = 011 -> hits = 0, f_q = 0, f_rise = 0; F stays 1 throughout.

Source files
------------

// File: rtl/top.sv
// Majority voter on {A,B,C} with minterm/popcount decode, plus a registered
// copy of F, a rising-edge pulse and a saturating count of cycles that saw F = 1.
module top (
    input  logic        A,
    input  logic        B,
    input  logic        C,
    output logic        F,
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  m,
    output logic [1:0]  ones,
    output logic        f_q,
    output logic        f_rise,
    output logic [15:0] hits
);

    localparam logic [15:0] HITS_MAX = 16'hFFFF;

    logic [2:0] index;

    // Combinational decode never touches clk or rst, so it stays valid even with the clock undriven
    assign index = {A, B, C};
    assign F     = (A & B) | (A & C) | (B & C);
    assign m     = 8'b0000_0001 << index;
    assign ones  = {1'b0, A} + {1'b0, B} + {1'b0, C};

    // f_rise compares the current F against f_q from the previous edge
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= 1'b0;
            f_rise <= 1'b0;
            hits   <= '0;
        end else begin
            f_q    <= F;
            f_rise <= F & ~f_q;
            if (F && (hits != HITS_MAX)) begin
                hits <= hits + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: combinational decode with the clock stopped, then
// the registered f_q / f_rise / hits path including reset and saturation.
module tb_top;

    logic        A, B, C;
    logic        F;
    logic        clk;
    logic        rst;
    logic [7:0]  m;
    logic [1:0]  ones;
    logic        f_q;
    logic        f_rise;
    logic [15:0] hits;

    logic        clk_en;
    int          tests_run;
    int          tests_failed;

    logic [7:0]  f_tab;
    logic [1:0]  ones_tab [8];

    top dut (
        .A      (A),
        .B      (B),
        .C      (C),
        .F      (F),
        .clk    (clk),
        .rst    (rst),
        .m      (m),
        .ones   (ones),
        .f_q    (f_q),
        .f_rise (f_rise),
        .hits   (hits)
    );

    // Clock only toggles once enabled, so the first tests run with no edges at all
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string name, input logic exp_fq,
                              input logic exp_rise, input logic [15:0] exp_hits);
        tests_run++;
        if (f_q !== exp_fq || f_rise !== exp_rise || hits !== exp_hits) begin
            tests_failed++;
            $display("[TB] FAIL %s: f_q=%b f_rise=%b hits=%h, expected f_q=%b f_rise=%b hits=%h",
                     name, f_q, f_rise, hits, exp_fq, exp_rise, exp_hits);
        end
    endtask

    task automatic test_no_clock();
        {A, B, C} = 3'b110;
        #5;
        tests_run++;
        if (F !== 1'b1 || m !== 8'b0100_0000 || ones !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL no_clock_110: F=%b m=%b ones=%0d, expected F=1 m=01000000 ones=2",
                     F, m, ones);
        end
    endtask

    task automatic test_sweep();
        logic [2:0] idx;
        logic [7:0] exp_m;
        for (int i = 0; i < 8; i++) begin
            idx   = i[2:0];
            exp_m = 8'b0000_0001 << idx;
            {A, B, C} = idx;
            #5;
            tests_run++;
            if (F !== f_tab[idx] || ones !== ones_tab[i] || m !== exp_m) begin
                tests_failed++;
                $display("[TB] FAIL sweep_%0d: F=%b m=%b ones=%0d, expected F=%b m=%b ones=%0d",
                         i, F, m, ones, f_tab[idx], exp_m, ones_tab[i]);
            end
        end
    endtask

    task automatic test_reset();
        {A, B, C} = 3'b111;
        rst = 1'b1;
        step();
        step();
        check_regs("reset_hold", 1'b0, 1'b0, 16'd0);
        tests_run++;
        if (F !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_keeps_F: F=%b, expected 1", F);
        end
        rst = 1'b0;
        step();
        check_regs("first_edge_rise", 1'b1, 1'b1, 16'd1);
        step();
        check_regs("second_edge", 1'b1, 1'b0, 16'd2);
        step();
        check_regs("third_edge", 1'b1, 1'b0, 16'd3);
    endtask

    task automatic test_hold();
        step();
        step();
        check_regs("count_to_5", 1'b1, 1'b0, 16'd5);
        {A, B, C} = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            check_regs($sformatf("hold_edge_%0d", i), 1'b0, 1'b0, 16'd5);
        end
    endtask

    task automatic test_mid_reset();
        {A, B, C} = 3'b111;
        step();
        check_regs("recount_rise", 1'b1, 1'b1, 16'd6);
        step();
        check_regs("count_to_7", 1'b1, 1'b0, 16'd7);
        {A, B, C} = 3'b011;
        rst = 1'b1;
        #1;
        tests_run++;
        if (F !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_F_before: F=%b, expected 1", F);
        end
        step();
        check_regs("mid_reset_clear", 1'b0, 1'b0, 16'd0);
        tests_run++;
        if (F !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_F_after: F=%b, expected 1", F);
        end
        rst = 1'b0;
        step();
        check_regs("after_mid_reset", 1'b1, 1'b1, 16'd1);
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        step();
        rst = 1'b0;
        {A, B, C} = 3'b101;
        repeat (65534) @(posedge clk);
        #1;
        check_regs("near_max", 1'b1, 1'b0, 16'hFFFE);
        step();
        check_regs("at_max", 1'b1, 1'b0, 16'hFFFF);
        step();
        check_regs("sat_edge_1", 1'b1, 1'b0, 16'hFFFF);
        step();
        check_regs("sat_edge_2", 1'b1, 1'b0, 16'hFFFF);
        {A, B, C} = 3'b001;
        step();
        check_regs("sat_f_low", 1'b0, 1'b0, 16'hFFFF);
        {A, B, C} = 3'b011;
        step();
        check_regs("sat_rise", 1'b1, 1'b1, 16'hFFFF);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        f_tab        = 8'b1110_1000;
        ones_tab     = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        clk          = 1'b0;
        clk_en       = 1'b0;
        rst          = 1'b0;
        {A, B, C}    = 3'b000;

        test_no_clock();
        test_sweep();

        rst    = 1'b1;
        clk_en = 1'b1;
        test_reset();
        test_hold();
        test_mid_reset();
        test_saturate();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
